// File: rtl/netlist_eval_arbiter.sv
// netlist_eval_arbiter: round-robin time-sharing of one combinational netlist between requesters
module netlist_eval_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IN_W = 14,
  parameter int OUT_W = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [OUT_W-1:0]        resp_data,
  output logic [IN_W-1:0]         nl_in,
  input  logic [OUT_W-1:0]        nl_out,
  output logic                    busy,
  output logic [2:0]              grant_id,
  output logic [CNT_W-1:0]        done_cnt
);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  state_t state, state_nx;
  logic [2:0] rr_ptr, win_id;
  logic [3:0] cnt;
  logic accept, hs;
  assign accept = state == IDLE && |req_valid;
  assign hs = |(resp_valid & resp_ready);
  // round-robin winner search; scanning backwards lets the requester nearest rr_ptr win
  always_comb begin
    win_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (|(req_valid & (NUM_REQ'(1) << ((int'(rr_ptr) + k) % NUM_REQ))))
        win_id = 3'((int'(rr_ptr) + k) % NUM_REQ);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state logic
  always_comb
    state_nx = state == IDLE ? (accept ? SETTLE : IDLE) :
               state == SETTLE ? (cnt == 4'd0 ? RESP : SETTLE) :
               (hs ? IDLE : RESP);
  // handshake outputs decoded from state and current owner
  always_comb begin
    req_ready = accept ? NUM_REQ'(1) << win_id : '0;
    resp_valid = state == RESP ? NUM_REQ'(1) << grant_id : '0;
    busy = state != IDLE;
  end
  // launch, settle countdown, capture and completion bookkeeping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      nl_in <= '0;
      resp_data <= '0;
      grant_id <= '0;
      rr_ptr <= '0;
      cnt <= '0;
      done_cnt <= '0;
    end else begin
      if (accept) begin
        nl_in <= req_data[int'(win_id)*IN_W +: IN_W];
        grant_id <= win_id;
        cnt <= 4'(SETTLE_CYCLES - 1);
      end
      if (state == SETTLE) begin
        cnt <= cnt == 4'd0 ? cnt : cnt - 4'd1;
        if (cnt == 4'd0) resp_data <= nl_out;
      end
      if (hs) begin
        done_cnt <= done_cnt + CNT_W'(1);
        rr_ptr <= grant_id == 3'(NUM_REQ - 1) ? 3'd0 : grant_id + 3'd1;
      end
    end
endmodule
